// File: rtl/demux8_deser_pkg.sv
`default_nettype none
// ============================================================================
// Module   : demux8_deser_pkg
// Purpose  : Shared lane count, lane-index width and lane index type.
// Revision : 1.0 - initial release
// ============================================================================
package demux8_deser_pkg;

  localparam int LANES = 8;
  localparam int SEL_W = $clog2(LANES);

  typedef logic [SEL_W-1:0] lane_idx_t;

endpackage : demux8_deser_pkg
`default_nettype wire

// File: rtl/demux8_deser_lane_counter.sv
`default_nettype none
// ============================================================================
// Module   : demux8_deser_lane_counter
// Purpose  : Lane index for the deserializer; sof restarts at lane 1 because
//            the sof bit itself occupies lane 0.
// Revision : 1.0 - initial release
// ============================================================================
module demux8_deser_lane_counter
  import demux8_deser_pkg::*;
#(
  parameter int LANES = demux8_deser_pkg::LANES,
  parameter int SEL_W = $clog2(LANES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             sof,
  output logic [SEL_W-1:0] idx,
  output logic             last_lane
);

  logic [SEL_W-1:0] r_idx;

  assign idx       = r_idx;
  assign last_lane = (r_idx == SEL_W'(LANES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
    end else if (inc) begin
      if (sof)
        r_idx <= SEL_W'(1);
      else if (last_lane)
        r_idx <= '0;
      else
        r_idx <= r_idx + SEL_W'(1);
    end
  end

endmodule : demux8_deser_lane_counter
`default_nettype wire

// File: rtl/demux8_deser.sv
`default_nettype none
// ============================================================================
// Module   : demux8_deser
// Purpose  : Serial-to-parallel lane demultiplexer with valid/ready output
//            and a sticky overrun flag for words dropped on backpressure.
// Revision : 1.0 - initial release
// ============================================================================
module demux8_deser
  import demux8_deser_pkg::*;
#(
  parameter int LANES = demux8_deser_pkg::LANES,
  parameter int SEL_W = $clog2(LANES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_valid,
  input  logic             sof,
  output logic [LANES-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [SEL_W-1:0] sel,
  output logic             overrun,
  input  logic             clr_ovr
);

  logic [SEL_W-1:0] w_idx;
  logic             w_last_lane;
  logic [LANES-2:0] r_shadow;
  logic [LANES-2:0] w_shadow_next;
  logic [LANES-1:0] w_word;
  logic             w_complete;
  logic             w_can_load;
  logic [LANES-1:0] r_dout;
  logic             r_dout_valid;
  logic             r_overrun;

  demux8_deser_lane_counter #(
    .LANES (LANES),
    .SEL_W (SEL_W)
  ) u_lane_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc       (din_valid),
    .sof       (sof),
    .idx       (w_idx),
    .last_lane (w_last_lane)
  );

  assign w_word     = {din, r_shadow};
  assign w_complete = din_valid && !sof && w_last_lane;
  assign w_can_load = !r_dout_valid || dout_ready;

  always_comb begin
    w_shadow_next = r_shadow;
    if (din_valid) begin
      if (sof) begin
        w_shadow_next    = '0;
        w_shadow_next[0] = din;
      end else if (w_last_lane) begin
        w_shadow_next = '0;
      end else begin
        for (int k = 0; k < LANES - 1; k++)
          if (w_idx == SEL_W'(k))
            w_shadow_next[k] = din;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_shadow <= '0;
    else
      r_shadow <= w_shadow_next;
  end

  // A completing word outranks the consumer's pop so accept-and-reload gives no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      if (w_complete && w_can_load) begin
        r_dout       <= w_word;
        r_dout_valid <= 1'b1;
      end else if (r_dout_valid && dout_ready) begin
        r_dout_valid <= 1'b0;
      end

      if (w_complete && !w_can_load)
        r_overrun <= 1'b1;
      else if (clr_ovr)
        r_overrun <= 1'b0;
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign sel        = w_idx;
  assign overrun    = r_overrun;

endmodule : demux8_deser
`default_nettype wire

// File: tb/tb_demux8_deser.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux8_deser
// Purpose  : Directed self-checking bench for demux8_deser.
// Revision : 1.0 - initial release
// ============================================================================
module tb_demux8_deser;
  import demux8_deser_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       din;
  logic       din_valid;
  logic       sof;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  lane_idx_t  sel;
  logic       overrun;
  logic       clr_ovr;

  int checks;
  int errors;

  demux8_deser dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .sof        (sof),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .sel        (sel),
    .overrun    (overrun),
    .clr_ovr    (clr_ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic s);
    din       = b;
    sof       = s;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    sof       = 1'b0;
    din       = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; din = 0; din_valid = 0; sof = 0; dout_ready = 0; clr_ovr = 0;
    #12;
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout got %h want 00", dout); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", dout_valid); end
    checks++; if (sel !== 3'd0) begin errors++; $display("FAIL reset_sel got %0d want 0", sel); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr got %b want 0", overrun); end
    rst_n = 1'b1;
  endtask

  task automatic test_single_word();
    logic [7:0] w;
    int early;
    w = 8'h4D; early = 0;
    dout_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send_bit(w[i], i == 0);
      if (i < 7 && dout_valid !== 1'b0) early++;
    end
    checks++; if (early != 0) begin errors++; $display("FAIL single_early_valid got %0d want 0", early); end
    checks++; if (dout !== 8'h4D) begin errors++; $display("FAIL single_dout got %h want 4d", dout); end
    checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", dout_valid); end
    checks++; if (sel !== 3'd0) begin errors++; $display("FAIL single_sel got %0d want 0", sel); end
    step();
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL single_pulse got %b want 0", dout_valid); end
    checks++; if (dout !== 8'h4D) begin errors++; $display("FAIL single_hold got %h want 4d", dout); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] ws;
    int pulses;
    int bad_pos;
    ws = 16'h3CA5; pulses = 0; bad_pos = 0;
    dout_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send_bit(ws[i], i == 0);
      if (dout_valid === 1'b1) begin
        pulses++;
        if (i != 7 && i != 15) bad_pos++;
      end
      if (i == 7) begin
        checks++; if (dout !== 8'hA5) begin errors++; $display("FAIL b2b_word1 got %h want a5", dout); end
      end
    end
    checks++; if (dout !== 8'h3C) begin errors++; $display("FAIL b2b_word2 got %h want 3c", dout); end
    checks++; if (pulses != 2) begin errors++; $display("FAIL b2b_pulses got %0d want 2", pulses); end
    checks++; if (bad_pos != 0) begin errors++; $display("FAIL b2b_pulse_pos got %0d want 0", bad_pos); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_ovr got %b want 0", overrun); end
    step();
  endtask

  task automatic test_overrun();
    dout_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_bit(1'b1, i == 0);
    checks++; if (dout_valid !== 1'b1 || dout !== 8'hFF) begin errors++; $display("FAIL ovr_first got v=%b d=%h want v=1 d=ff", dout_valid, dout); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_early got %b want 0", overrun); end
    for (int i = 0; i < 8; i++) send_bit(1'b0, 1'b0);
    checks++; if (dout !== 8'hFF) begin errors++; $display("FAIL ovr_hold got %h want ff", dout); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got %b want 1", overrun); end
    clr_ovr = 1'b1;
    step();
    clr_ovr = 1'b0;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear got %b want 0", overrun); end
    checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL ovr_still_valid got %b want 1", dout_valid); end
    dout_ready = 1'b1;
    step();
    checks++; if (dout_valid !== 1'b0 || dout !== 8'hFF) begin errors++; $display("FAIL ovr_drain got v=%b d=%h want v=0 d=ff", dout_valid, dout); end
  endtask

  task automatic test_sof_restart();
    int early;
    early = 0;
    dout_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send_bit(1'b1, i == 0);
      if (dout_valid !== 1'b0) early++;
    end
    send_bit(1'b1, 1'b1);
    checks++; if (sel !== 3'd1) begin errors++; $display("FAIL sof_sel got %0d want 1", sel); end
    for (int i = 0; i < 7; i++) begin
      send_bit(1'b0, 1'b0);
      if (i < 6 && dout_valid !== 1'b0) early++;
    end
    checks++; if (early != 0) begin errors++; $display("FAIL sof_partial got %0d want 0", early); end
    checks++; if (dout_valid !== 1'b1 || dout !== 8'h01) begin errors++; $display("FAIL sof_word got v=%b d=%h want v=1 d=01", dout_valid, dout); end
    step();
  endtask

  task automatic test_gapped();
    logic [7:0] w;
    lane_idx_t exp_sel;
    int bad_sel;
    w = 8'hC3; bad_sel = 0;
    dout_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send_bit(w[i], i == 0);
      exp_sel = lane_idx_t'((i + 1) % 8);
      if (sel !== exp_sel) bad_sel++;
      if (i == 7) begin
        checks++; if (dout_valid !== 1'b1 || dout !== 8'hC3) begin errors++; $display("FAIL gap_word got v=%b d=%h want v=1 d=c3", dout_valid, dout); end
      end
      din = ~w[i]; sof = 1'b1;
      step();
      if (sel !== exp_sel) bad_sel++;
      sof = 1'b0;
    end
    checks++; if (bad_sel != 0) begin errors++; $display("FAIL gap_sel got %0d bad want 0", bad_sel); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL gap_drain got %b want 0", dout_valid); end
  endtask

  task automatic test_async_reset();
    logic [7:0] w;
    dout_ready = 1'b0;
    w = 8'h5A;
    for (int i = 0; i < 8; i++) send_bit(w[i], i == 0);
    for (int i = 0; i < 8; i++) send_bit(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    checks++; if (dout_valid !== 1'b1 || overrun !== 1'b1 || sel !== 3'd4) begin errors++; $display("FAIL pre_rst got v=%b o=%b s=%0d want 1 1 4", dout_valid, overrun, sel); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (dout !== 8'h00 || dout_valid !== 1'b0) begin errors++; $display("FAIL arst_out got v=%b d=%h want v=0 d=00", dout_valid, dout); end
    checks++; if (sel !== 3'd0 || overrun !== 1'b0) begin errors++; $display("FAIL arst_state got s=%0d o=%b want 0 0", sel, overrun); end
    step();
    rst_n = 1'b1;
    dout_ready = 1'b1;
    w = 8'h96;
    for (int i = 0; i < 8; i++) send_bit(w[i], 1'b0);
    checks++; if (dout_valid !== 1'b1 || dout !== 8'h96) begin errors++; $display("FAIL arst_clean got v=%b d=%h want v=1 d=96", dout_valid, dout); end
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_overrun();
    test_sof_restart();
    test_gapped();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_demux8_deser
`default_nettype wire

// File: doc/demux8_deser.md
Name: demux8_deser

Overview:
- Serial-to-parallel lane demultiplexer, the receive end of a select-counter-driven 8:1 mux serializer.
- Steers one serial bit per valid cycle into lane din-index 0..7, in order.
- Presents the assembled 8-bit word with a valid/ready handshake.
- Sits between a serial link input and the parallel datapath; frame alignment is via a start-of-frame strobe.

Parameters:
- LANES, 8, number of output lanes; power of two, at least 2.
- SEL_W, 3, lane index width; equals log2(LANES).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- din  in  1  serial data bit.
- din_valid  in  1  din is sampled on this edge when high.
- sof  in  1  qualified by din_valid; marks the current bit as lane 0 of a new word.
- dout  out  LANES  assembled word; bit k holds the k-th bit received.
- dout_valid  out  1  dout holds an unconsumed word.
- dout_ready  in  1  consumer accepts dout when dout_valid is also high.
- sel  out  SEL_W  lane index the next valid bit will be written to.
- overrun  out  1  sticky flag: a completed word was dropped.
- clr_ovr  in  1  synchronous clear of overrun.

Behaviour:
- Reset is asynchronous on rst_n low: shadow, dout, dout_valid, sel and overrun all go to 0.
- Internal state:
  - shadow register, LANES-1 bits.
  - lane index idx, which is driven directly on sel.
  - output register dout with dout_valid.
- din_valid low: shadow and idx hold. The output side still processes the handshake.
- din_valid high, sof low, idx < LANES-1: shadow[idx] <= din, idx <= idx+1.
- din_valid high, sof high:
  - The partial word is discarded: shadow is cleared, then shadow[0] <= din, idx <= 1.
  - sof on the final-lane position also restarts the word; no word completes.
- din_valid high, sof low, idx == LANES-1 (word complete):
  - The candidate word is {din, shadow[LANES-2:0]}.
  - idx wraps to 0; shadow is cleared.
- Load rule for a completed word:
  - If dout_valid is low, or dout_valid and dout_ready are both high this cycle: dout <= word and dout_valid <= 1.
  - Otherwise (dout_valid high, dout_ready low): the new word is dropped, dout keeps the old word, and overrun <= 1.
- Handshake:
  - dout_valid && dout_ready with no completing word: dout_valid <= 0, and dout holds its value.
  - dout is stable while dout_valid is high and dout_ready is low.
- Latency: the bit that completes the word is sampled at edge N; dout_valid is high from edge N.
  - Full word with gap-free input: 8 edges from the first bit to dout_valid.
  - Back-to-back words with dout_ready held high: one dout_valid per 8 valid bits, with no bubbles.
- overrun:
  - Set by a drop, cleared by clr_ovr.
  - Set wins if both occur in the same cycle.
- din and sof are ignored when din_valid is low.
- dout_ready is ignored when dout_valid is low.
- Arithmetic: idx is SEL_W bits with natural wrap; no other arithmetic.
- Asserting rst_n low mid-word discards the partial word and any held dout. The first bit after release goes to lane 0.

Decomposition:
- Shared package holds:
  - LANES default and SEL_W (computed as $clog2(LANES)).
  - A lane_idx_t typedef of logic [SEL_W-1:0].
- Sub-module lane_counter:
  - idx register with increment on din_valid.
  - Reset-to-1 on sof.
  - Wrap at LANES-1, with a last_lane output.
- The top level holds shadow, the output register, the handshake and overrun.

Test Plan:
- Reset then 8 valid bits 1,0,1,1,0,0,1,0 with sof on the first bit and dout_ready=1 -> dout=8'h4D, dout_valid high for exactly 1 cycle at the 8th edge, sel=0 afterwards.
- Two gap-free words 8'hA5 then 8'h3C with dout_ready=1 -> two single-cycle dout_valid pulses 8 cycles apart, no overrun.
- Word 8'hFF with dout_ready=0, then a second word 8'h00 -> dout stays 8'hFF, overrun=1; clr_ovr pulse -> overrun=0; dout_ready=1 -> dout_valid falls.
- 5 bits, then sof with din=1 followed by 7 bits of 0 -> dout=8'h01; the partial word never appears.
- din_valid toggling every other cycle over word 8'hC3 -> correct dout; sel advances only on valid cycles.
- rst_n low after 4 bits and while dout_valid=1 -> all outputs 0 asynchronously; the next 8 bits produce a clean word.
